// File: rtl/adxl345_spi_reader.sv
// rtl/adxl345_spi_reader.sv - ADXL345 SPI (mode 3) initialiser and X/Y/Z burst reader
//
// Purpose: after reset writes DATA_FORMAT (0x31 <= 0x0B) and POWER_CTL (0x2D <= 0x08),
//   then performs one 6-byte burst read from 0x32 per rising edge of sample_req seen in IDLE.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   sample_req               slow request strobe; rising edge starts a read (IDLE only)
//   spi_sclk/cs_n/mosi/miso  4-wire SPI, mode 3, MSB first; sclk idles high
//   accel_x/y/z              signed 16-bit axis samples {DATAn1,DATAn0}
//   data_valid               one-cycle pulse when accel_* update
//   busy                     high in every state except IDLE
//   init_done                sticky once both init writes are complete
// Configuration: define ACCEL_AVG4_EN to output a 4-sample moving average per axis
//   (one extra cycle of latency); undefined outputs raw samples.
module adxl345_spi_reader #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCLK_FREQ = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_req,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        data_valid,
  output logic        busy,
  output logic        init_done
);

  localparam int HALF = CLK_FREQ / (2 * SCLK_FREQ);
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(HALF - 1);
  // Phase 0 is setup, phases 1..16*bytes are bit halves, the final phase is hold.
  localparam logic [6:0] WR_LAST = 7'd33;
  localparam logic [6:0] RD_LAST = 7'd113;

  typedef enum logic [2:0] {INIT_FMT, INIT_PWR, READ, GAP, IDLE} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hc;
  logic [6:0]    ph;
  logic          act;        // cs_n has been asserted for the current transaction
  logic          req_q;
  logic          pwr_done;
  logic [47:0]   rx_sr;
  logic          req_edge, xfer, half_end, rd_done;
  logic [6:0]    last_ph;
  logic [7:0]    tx_byte;
  logic [15:0]   raw_x, raw_y, raw_z;

  assign req_edge = sample_req & ~req_q;
  assign xfer     = (state == INIT_FMT) || (state == INIT_PWR) || (state == READ);
  assign half_end = (hc == HC_LAST);
  assign last_ph  = (state == READ) ? RD_LAST : WR_LAST;
  assign busy     = (state != IDLE);
  assign rd_done  = (state == READ) && (state_n == GAP);

  // The shift register keeps only the last six bytes, so the command byte falls out.
  assign raw_x = {rx_sr[39:32], rx_sr[47:40]};
  assign raw_y = {rx_sr[23:16], rx_sr[31:24]};
  assign raw_z = {rx_sr[7:0],   rx_sr[15:8]};

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      INIT_FMT: tx_byte = (ph[6:4] == 3'd0) ? 8'h31 : 8'h0B;
      INIT_PWR: tx_byte = (ph[6:4] == 3'd0) ? 8'h2D : 8'h08;
      READ:     tx_byte = (ph[6:4] == 3'd0) ? 8'hF2 : 8'h00;
      default:  tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_FMT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT_FMT, INIT_PWR, READ:
        if (act && half_end && (ph == last_ph)) state_n = GAP;
      GAP:
        if (half_end && (ph == 7'd1)) state_n = pwr_done ? IDLE : INIT_PWR;
      IDLE:
        if (req_edge) state_n = READ;
      default: state_n = INIT_FMT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      hc        <= '0;
      ph        <= '0;
      act       <= 1'b0;
      pwr_done  <= 1'b0;
      init_done <= 1'b0;
      spi_sclk  <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      rx_sr     <= '0;
    end else begin
      req_q <= sample_req;

      if (state_n != state) begin
        hc  <= '0;
        ph  <= '0;
        act <= 1'b0;
      end else if (act || (state == GAP)) begin
        if (half_end) begin
          hc <= '0;
          ph <= ph + 7'd1;
        end else begin
          hc <= hc + HW'(1);
        end
      end

      if (xfer) begin
        if (!act) begin
          spi_cs_n <= 1'b0;
          act      <= 1'b1;
        end else if (half_end) begin
          if (ph == last_ph) begin
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
          end else if (ph < (last_ph - 7'd1)) begin
            // Even phase ending -> falling sclk with new mosi; odd -> rising sclk, sample miso.
            if (!ph[0]) begin
              spi_sclk <= 1'b0;
              spi_mosi <= tx_byte[3'd7 - ph[3:1]];
            end else begin
              spi_sclk <= 1'b1;
              rx_sr    <= {rx_sr[46:0], spi_miso};
            end
          end
        end
      end

      if ((state == INIT_PWR) && (state_n == GAP)) pwr_done <= 1'b1;
      if ((state == GAP) && (state_n == IDLE))     init_done <= 1'b1;
    end
  end

`ifdef ACCEL_AVG4_EN
  logic [15:0] hist_x [4];
  logic [15:0] hist_y [4];
  logic [15:0] hist_z [4];
  logic        avg_pend;

  function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    logic [17:0] s;
    s = {{2{a[15]}}, a} + {{2{b[15]}}, b} + {{2{c[15]}}, c} + {{2{d[15]}}, d};
    return s[17:2];  // arithmetic >>> 2 of an 18-bit sum, rounds toward -inf
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
        hist_z[i] <= '0;
      end
      avg_pend   <= 1'b0;
      data_valid <= 1'b0;
      accel_x    <= '0;
      accel_y    <= '0;
      accel_z    <= '0;
    end else begin
      avg_pend   <= rd_done;
      data_valid <= avg_pend;
      if (rd_done) begin
        hist_x[0] <= raw_x;
        hist_y[0] <= raw_y;
        hist_z[0] <= raw_z;
        for (int i = 1; i < 4; i++) begin
          hist_x[i] <= hist_x[i-1];
          hist_y[i] <= hist_y[i-1];
          hist_z[i] <= hist_z[i-1];
        end
      end
      if (avg_pend) begin
        accel_x <= avg4(hist_x[0], hist_x[1], hist_x[2], hist_x[3]);
        accel_y <= avg4(hist_y[0], hist_y[1], hist_y[2], hist_y[3]);
        accel_z <= avg4(hist_z[0], hist_z[1], hist_z[2], hist_z[3]);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      accel_x    <= '0;
      accel_y    <= '0;
      accel_z    <= '0;
    end else begin
      data_valid <= rd_done;
      if (rd_done) begin
        accel_x <= raw_x;
        accel_y <= raw_y;
        accel_z <= raw_z;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adxl345_spi_reader.sv
// tb/tb_adxl345_spi_reader.sv - scoreboard bench for adxl345_spi_reader with an ADXL345 slave model
module tb_adxl345_spi_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_req;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        data_valid, busy, init_done;

`ifdef ACCEL_AVG4_EN
  localparam int LAT = 458;
`else
  localparam int LAT = 457;
`endif

  adxl345_spi_reader #(.CLK_FREQ(8_000_000), .SCLK_FREQ(1_000_000)) dut (
    .clk(clk), .rst(rst), .sample_req(sample_req),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .data_valid(data_valid), .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] b0; logic [7:0] b1; int nbytes; int len; } frame_t;
  typedef struct { int cyc; logic [15:0] x; logic [15:0] y; logic [15:0] z; } dv_t;
  frame_t fq[$];
  dv_t    dq[$];

  // ADXL345 slave model: drives miso on sclk falling, captures mosi on sclk rising.
  logic [7:0] sdata [6];
  logic [7:0] mb[$];
  logic [7:0] rsh;
  int rcnt, fcnt;

  always @(negedge spi_cs_n) begin
    fcnt = 0; rcnt = 0; rsh = 8'h00; mb.delete();
  end

  always @(posedge spi_sclk) if (spi_cs_n === 1'b0) begin
    rsh = {rsh[6:0], spi_mosi};
    rcnt++;
    if (rcnt == 8) begin
      mb.push_back(rsh);
      rcnt = 0;
    end
  end

  always @(negedge spi_sclk) if (spi_cs_n === 1'b0) begin
    int bi;
    bi = fcnt >> 3;
    if (bi >= 1 && bi <= 6) spi_miso = sdata[bi-1][7 - (fcnt & 7)];
    else                    spi_miso = 1'b0;
    fcnt++;
  end

  // Frame monitor: length of cs_n low, bytes seen, idle gap between frames.
  int  lowcnt = 0, hicnt = 0;
  bit  in_frame = 0, have_prev = 0;
  frame_t fe;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0; have_prev = 0; lowcnt = 0; hicnt = 0;
    end else if (spi_cs_n === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1;
        lowcnt = 0;
        if (have_prev) chk("cs_gap_ge_8", (hicnt >= 8), 1);
      end
      lowcnt++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        have_prev = 1;
        hicnt = 0;
        if (fq.size() == 0) chk("unexpected_cs_frame", 0, 1);
        else begin
          fe = fq.pop_front();
          chk("frame_nbytes", mb.size(), fe.nbytes);
          chk("frame_byte0", (mb.size() > 0) ? mb[0] : 8'hxx, fe.b0);
          chk("frame_byte1", (mb.size() > 1) ? mb[1] : 8'hxx, fe.b1);
          chk("frame_cs_low_cycles", lowcnt, fe.len);
        end
      end
      hicnt++;
    end
  end

  // Data monitor
  dv_t de;
  always @(negedge clk) if (!rst && data_valid === 1'b1) begin
    if (dq.size() == 0) chk("unexpected_data_valid", 0, 1);
    else begin
      de = dq.pop_front();
      chk("data_valid_cycle", cyc, de.cyc);
      chk("accel_x", accel_x, de.x);
      chk("accel_y", accel_y, de.y);
      chk("accel_z", accel_z, de.z);
    end
  end

  task automatic push_init();
    fq.push_back('{b0: 8'h31, b1: 8'h0B, nbytes: 2, len: 136});
    fq.push_back('{b0: 8'h2D, b1: 8'h08, nbytes: 2, len: 136});
  endtask

  task automatic set_xyz(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sdata[0] = x[7:0]; sdata[1] = x[15:8];
    sdata[2] = y[7:0]; sdata[3] = y[15:8];
    sdata[4] = z[7:0]; sdata[5] = z[15:8];
  endtask

  task automatic wait_ready(input int maxc);
    int n;
    n = 0;
    while (!(init_done === 1'b1 && busy === 1'b0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("ready_within_budget", (init_done === 1'b1 && busy === 1'b0), 1);
  endtask

  task automatic do_read(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez);
    @(negedge clk);
    sample_req = 1'b1;
    fq.push_back('{b0: 8'hF2, b1: 8'h00, nbytes: 7, len: 456});
    dq.push_back('{cyc: cyc + 1 + LAT, x: ex, y: ey, z: ez});
    repeat (10) @(negedge clk);
    sample_req = 1'b0;
    wait_ready(2000);
  endtask

  initial begin
    rst = 1'b1;
    sample_req = 1'b0;
    set_xyz(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    chk("reset_cs_n", spi_cs_n, 1);
    chk("reset_sclk", spi_sclk, 1);
    chk("reset_mosi", spi_mosi, 0);
    chk("reset_accel", {accel_x, accel_y, accel_z}, 0);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_busy", busy, 1);
    chk("reset_init_done", init_done, 0);

    // Init sequence; a request edge during init must be dropped.
    push_init();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sample_req = 1'b1;
    repeat (20) @(negedge clk);
    sample_req = 1'b0;
    wait_ready(2000);
    chk("init_done_after_init", init_done, 1);
    chk("busy_after_init", busy, 0);
    repeat (30) @(negedge clk);
    chk("init_frames_consumed", fq.size(), 0);
    chk("no_read_from_init_edge", dq.size(), 0);

    // Burst read, with a second edge landing mid-READ that must be ignored.
    set_xyz(16'h1234, 16'hFFFE, 16'h8000);
    @(negedge clk);
    sample_req = 1'b1;
    fq.push_back('{b0: 8'hF2, b1: 8'h00, nbytes: 7, len: 456});
`ifdef ACCEL_AVG4_EN
    dq.push_back('{cyc: cyc + 1 + LAT, x: 16'h048D, y: 16'hFFFF, z: 16'hE000});
`else
    dq.push_back('{cyc: cyc + 1 + LAT, x: 16'h1234, y: 16'hFFFE, z: 16'h8000});
`endif
    repeat (100) @(negedge clk);
    sample_req = 1'b0;
    repeat (50) @(negedge clk);
    sample_req = 1'b1;
    repeat (150) @(negedge clk);
    sample_req = 1'b0;
    wait_ready(2000);
    repeat (40) @(negedge clk);
    chk("read_frames_consumed", fq.size(), 0);
    chk("read_data_consumed", dq.size(), 0);

    // Reset 200 cycles into a READ
    @(negedge clk);
    sample_req = 1'b1;
    repeat (10) @(negedge clk);
    sample_req = 1'b0;
    repeat (190) @(negedge clk);
    chk("read_in_progress", spi_cs_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_cs_n", spi_cs_n, 1);
    chk("midreset_sclk", spi_sclk, 1);
    chk("midreset_accel", {accel_x, accel_y, accel_z}, 0);
    chk("midreset_init_done", init_done, 0);
    chk("midreset_busy", busy, 1);
    @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_ready(2000);
    repeat (30) @(negedge clk);
    chk("reinit_frames_consumed", fq.size(), 0);

    // Four reads of X = 100, 200, 300, -200
    set_xyz(16'd100, 16'h0000, 16'h0000);
`ifdef ACCEL_AVG4_EN
    do_read(16'd25, 16'h0000, 16'h0000);
    set_xyz(16'd200, 16'h0000, 16'h0000);
    do_read(16'd75, 16'h0000, 16'h0000);
    set_xyz(16'd300, 16'h0000, 16'h0000);
    do_read(16'd150, 16'h0000, 16'h0000);
    set_xyz(16'hFF38, 16'h0000, 16'h0000);
    do_read(16'd100, 16'h0000, 16'h0000);
`else
    do_read(16'd100, 16'h0000, 16'h0000);
    set_xyz(16'd200, 16'h0000, 16'h0000);
    do_read(16'd200, 16'h0000, 16'h0000);
    set_xyz(16'd300, 16'h0000, 16'h0000);
    do_read(16'd300, 16'h0000, 16'h0000);
    set_xyz(16'hFF38, 16'h0000, 16'h0000);
    do_read(16'hFF38, 16'h0000, 16'h0000);
`endif

    repeat (50) @(negedge clk);
    chk("final_frames_consumed", fq.size(), 0);
    chk("final_data_consumed", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
